// File: rtl/div.sv
// Signed 32-bit restoring divider; divStop pulses 33 cycles after an accepted start.
// Optional zero-divisor exception build: define DIV_ZERO_EXC_EN to add the divZero flag.
module div (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value_A_Dd,
  input  logic [31:0] value_B_Ds,
  input  logic        divInit,
  output logic [31:0] hi,
  output logic [31:0] lo,
`ifdef DIV_ZERO_EXC_EN
  output logic        divZero,
`endif
  output logic        divStop
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] mag_b;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] mag_a_in;
  logic [31:0] mag_b_in;
  logic [32:0] rem_sh;
  logic [33:0] trial;
  logic        keep;
  logic        last_iter;

  assign mag_a_in = value_A_Dd[31] ? (~value_A_Dd + 32'd1) : value_A_Dd;
  assign mag_b_in = value_B_Ds[31] ? (~value_B_Ds + 32'd1) : value_B_Ds;

  // Shift {R,Q} left one bit and try subtracting the divisor magnitude.
  assign rem_sh    = {rem[31:0], quo[31]};
  assign trial     = {1'b0, rem_sh} - {2'b00, mag_b};
  assign keep      = rem[32] | ~trial[33];
  assign last_iter = (cnt == 6'd32);

`ifdef DIV_ZERO_EXC_EN
  logic b_zero;
  assign b_zero = (value_B_Ds == 32'd0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (divInit) begin
`ifdef DIV_ZERO_EXC_EN
          state_nxt = b_zero ? DONE : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign divStop = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      rem     <= 33'd0;
      quo     <= 32'd0;
      mag_b   <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
`ifdef DIV_ZERO_EXC_EN
      divZero <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (divInit) begin
            cnt   <= 6'd0;
            rem   <= 33'd0;
            quo   <= mag_a_in;
            mag_b <= mag_b_in;
            neg_q <= value_A_Dd[31] ^ value_B_Ds[31];
            neg_r <= value_A_Dd[31];
`ifdef DIV_ZERO_EXC_EN
            divZero <= b_zero;
            if (b_zero) begin
              hi <= 32'd0;
              lo <= 32'd0;
            end
`endif
          end
        end
        CALC: begin
          // Results reach the outputs only once, on the edge that enters DONE.
          if (last_iter) begin
            lo <= neg_q ? (~quo + 32'd1) : quo;
            hi <= neg_r ? (~rem[31:0] + 32'd1) : rem[31:0];
          end else begin
            rem <= keep ? trial[32:0] : rem_sh;
            quo <= {quo[30:0], keep};
            cnt <= cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: stimulus pushes expected results, a negedge monitor pops on divStop.
module tb_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        divInit;
  logic [31:0] value_A_Dd;
  logic [31:0] value_B_Ds;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divStop;
`ifdef DIV_ZERO_EXC_EN
  logic        divZero;
`endif

  div dut (
    .clk        (clk),
    .reset      (reset),
    .value_A_Dd (value_A_Dd),
    .value_B_Ds (value_B_Ds),
    .divInit    (divInit),
    .hi         (hi),
    .lo         (lo),
`ifdef DIV_ZERO_EXC_EN
    .divZero    (divZero),
`endif
    .divStop    (divStop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          stop_cyc;
    bit          must;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit          z;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int completions = 0;

  // Reference: truncating signed division in 64-bit arithmetic, done edge e0.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input int e0, input bit must);
    exp_t   x;
    longint sa, sd, q, r;
    x.must = must; x.a = a; x.b = b; x.z = 1'b0;
    x.stop_cyc = e0 + 33;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    if (b == 32'd0) begin
`ifdef DIV_ZERO_EXC_EN
      x.q = 32'd0; x.r = 32'd0; x.z = 1'b1; x.stop_cyc = e0;
`else
      x.q = (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
      x.r = a;
`endif
    end else begin
      q = sa / sd;
      r = sa % sd;
      x.q = q[31:0];
      x.r = r[31:0];
    end
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rnd_a();
    int unsigned s;
    s = $urandom_range(0, 7);
    if (s == 0) return 32'h8000_0000;
    if (s == 1) return 32'($urandom_range(0, 300));
    return $urandom;
  endfunction

  function automatic logic [31:0] rnd_b();
    int unsigned s;
    s = $urandom_range(0, 7);
    if (s == 0) return 32'd0;
    if (s < 3)  return $urandom;
    if (s < 5)  return 32'($urandom_range(1, 20));
    if (s == 5) return 32'hFFFF_FFFF;
    return 32'(-int'($urandom_range(1, 20)));
  endfunction

  // Monitor: match each divStop to the entry due in this cycle, compare, and
  // verify hi/lo never move outside a completion or reset.
  logic [31:0] prev_hi = 32'd0;
  logic [31:0] prev_lo = 32'd0;
  bit          prev_rst = 1'b1;
  always @(negedge clk) begin
    exp_t x;
    if (divStop) begin
      while (sb.size() > 0 && sb[0].stop_cyc < cyc) begin
        x = sb.pop_front();
        if (x.must) begin
          checks++; errors++;
          $display("FAIL missed_stop A=%h B=%h due_cyc=%0d", x.a, x.b, x.stop_cyc);
        end
      end
      checks++;
      if (sb.size() == 0 || sb[0].stop_cyc != cyc) begin
        errors++;
        $display("FAIL stop_timing cyc=%0d expected_cyc=%0d", cyc,
                 (sb.size() > 0) ? sb[0].stop_cyc : -1);
      end else begin
        x = sb.pop_front();
        completions++;
        chk($sformatf("lo A=%h B=%h", x.a, x.b), lo, x.q);
        chk($sformatf("hi A=%h B=%h", x.a, x.b), hi, x.r);
`ifdef DIV_ZERO_EXC_EN
        chk($sformatf("divZero A=%h B=%h", x.a, x.b), 32'(divZero), 32'(x.z));
`endif
      end
    end
    if (!prev_rst && !divStop) begin
      chk("hi_hold", hi, prev_hi);
      chk("lo_hold", lo, prev_lo);
    end
    prev_hi  = hi;
    prev_lo  = lo;
    prev_rst = reset;
  end

  task automatic start(input logic [31:0] a, input logic [31:0] b, input bit must);
    @(posedge clk); #1;
    reset      = 1'b0;
    value_A_Dd = a;
    value_B_Ds = b;
    divInit    = 1'b1;
    sb.push_back(model(a, b, cyc + 1, must));
    @(posedge clk); #1;
    divInit    = 1'b0;
    value_A_Dd = $urandom;
    value_B_Ds = $urandom;
  endtask

  // Wait for the scoreboard to drain; while the divider is surely busy,
  // toggle divInit and operands, which must be ignored.
  task automatic wait_done(input bit poke);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      if (poke && i < 25) begin
        divInit    = 1'($urandom_range(0, 1));
        value_A_Dd = $urandom;
        value_B_Ds = $urandom;
      end else begin
        divInit = 1'b0;
      end
    end
    divInit = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout waiting for divStop, %0d pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    bit poke;
`ifdef DIV_ZERO_EXC_EN
    poke = (b != 32'd0);
`else
    poke = 1'b1;
`endif
    start(a, b, 1'b1);
    wait_done(poke);
  endtask

  logic [31:0] da [10] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000, 32'd5,
                           32'd1234, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
  logic [31:0] db [10] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd9,
                           32'd0, 32'd5, 32'h8000_0000, 32'd1, 32'h8000_0000};

  initial begin
    int base;
    reset      = 1'b1;
    divInit    = 1'b0;
    value_A_Dd = 32'd0;
    value_B_Ds = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_divStop", 32'(divStop), 32'd0);
`ifdef DIV_ZERO_EXC_EN
    chk("reset_divZero", 32'(divZero), 32'd0);
`endif

    // First start coincides with reset release.
    for (int i = 0; i < 10; i++) run(da[i], db[i]);
    for (int i = 0; i < 30; i++) run(rnd_a(), rnd_b());

    // Abort mid-calculation: no pulse may follow, outputs clear.
    start(32'd50, 32'd5, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_divStop", 32'(divStop), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    run(32'd50, 32'd5);

    // divInit held high, operands changing every cycle.
    base = completions;
    for (int i = 0; i < 160; i++) begin
      @(posedge clk); #1;
      value_A_Dd = rnd_a();
      value_B_Ds = rnd_b();
      divInit    = 1'b1;
      sb.push_back(model(value_A_Dd, value_B_Ds, cyc + 1, 1'b0));
    end
    @(posedge clk); #1;
    divInit = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    sb.delete();
    chk("hold_completions_ge4", 32'(completions - base >= 4), 32'd1);

    run(32'hFFFF_FF9C, 32'hFFFF_FFF9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
